sdram_req_arbiter: RTL and testbench
====================================

Name: sdram_req_arbiter

Overview:
Shares the single SDRAM controller port of the PPU between two requesters. The write requester is the N64 input line writer; the read requester is the scaler line prefetch. The block also schedules periodic auto-refresh. It grants fixed-length bursts, issues one command per grant to the SDRAM controller over a valid/ready handshake, and tracks data beats until the burst completes. It sits in the DRAM clock domain between the PPU line buffers and the SDRAM command engine.

Parameters:
ADDR_W, 22, width of burst start address (bank/row/column).
BURST_LEN, 8, data beats per granted burst (2..255).
REFRESH_INTERVAL, 780, DRAM clock cycles between refresh requests.
MAX_RD_STREAK, 4, consecutive read grants after which a pending write wins over read.

Ports:
DRAM_CLK_i  in  1  DRAM clock; all logic on rising edge.
DRAM_RST_i  in  1  synchronous active-high reset.
wr_req_i  in  1  write burst request; held until wr_gnt_o.
wr_addr_i  in  ADDR_W  write burst start address, valid with wr_req_i.
wr_gnt_o  out  1  high from grant until burst end.
wr_done_o  out  1  one-cycle pulse on last write beat.
rd_req_i  in  1  read burst request; held until rd_gnt_o.
rd_addr_i  in  ADDR_W  read burst start address.
rd_gnt_o  out  1  high from grant until burst end.
rd_done_o  out  1  one-cycle pulse on last read beat.
ctrl_cmd_valid_o  out  1  command valid to SDRAM controller.
ctrl_cmd_ready_i  in  1  controller accepts command.
ctrl_cmd_o  out  2  00 none, 01 write, 10 read, 11 refresh.
ctrl_addr_o  out  ADDR_W  latched burst address.
ctrl_beat_i  in  1  one data beat transferred.
ctrl_rfsh_done_i  in  1  refresh cycle finished.
busy_o  out  1  state != IDLE.
refresh_overrun_o  out  1  sticky: a refresh interval elapsed while a refresh was still pending.

Behaviour:
- Reset (any cycle, including mid-burst): state IDLE; all outputs 0; ctrl_addr_o 0; beat counter 0; rd_streak 0; refresh pending cleared; refresh counter loaded with REFRESH_INTERVAL-1. Any in-flight burst is abandoned with no done pulse.
- Refresh timer: decrements every cycle. At 0 it reloads and sets rfsh_pend. If rfsh_pend is already set at 0, refresh_overrun_o is set and stays set until reset.
- States: IDLE, CMD (valid asserted, awaiting ready), XFER (counting beats), RFSH (awaiting ctrl_rfsh_done_i).
- IDLE arbitration, evaluated every cycle, priority in this order:
  1. rfsh_pend.
  2. wr_req_i when rd_streak == MAX_RD_STREAK.
  3. rd_req_i.
  4. wr_req_i.
- The winner is registered. Next cycle: state CMD, ctrl_cmd_valid_o=1, ctrl_cmd_o/ctrl_addr_o latched, and the matching gnt_o=1 (refresh asserts no grant). Grant-to-command latency is 1 cycle.
- rd_streak: increments (saturating at MAX_RD_STREAK) on each read grant. Cleared on a write grant. Cleared in IDLE when rd_req_i=0.
- CMD: command, address and valid held stable until ctrl_cmd_ready_i=1. On that cycle valid drops next cycle. Refresh goes to RFSH and clears rfsh_pend; write/read go to XFER.
- XFER: beat counter counts ctrl_beat_i pulses. On beat BURST_LEN the block pulses done_o for 1 cycle and deasserts gnt_o the same cycle; the next cycle is IDLE. A new arbitration can grant 1 cycle after done_o.
- ctrl_beat_i in IDLE, CMD or RFSH is ignored. ctrl_rfsh_done_i outside RFSH is ignored.
- RFSH: on ctrl_rfsh_done_i, go to IDLE.
- A request dropped before grant is withdrawn and produces no grant. Requests are ignored while busy. rfsh_pend set during a burst is served at the next IDLE.
- Simultaneous rfsh_pend, wr and rd in IDLE: refresh first, then per priority.

Optional Feature:
SDRAM_ARB_STATS_EN
- Defined: adds input stats_clr_i plus outputs wr_grants_o[15:0], rd_grants_o[15:0] and max_wait_o[15:0].
  - wr_grants_o and rd_grants_o are saturating grant counters.
  - max_wait_o is the largest number of cycles any request spent high before its grant, saturating.
  - stats_clr_i (synchronous) or reset zeroes all three.
- Not defined: these ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, idle 780 cycles → ctrl_cmd_o=11 with valid at cycle 781. With ready=1 and rfsh_done 3 cycles later, state returns to IDLE; refresh_overrun_o stays 0.
- wr_req_i with addr 0x000123, ready=1, 8 beats → wr_gnt_o asserts 1 cycle after the request. ctrl_cmd_o=01 and ctrl_addr_o=0x000123. wr_done_o pulses with beat 8 and wr_gnt_o drops the same cycle.
- rd_req_i and wr_req_i held continuously → grant order RD,RD,RD,RD,WR,RD…; the write occupies every 5th grant.
- Refresh due mid read burst → the burst completes, rd_done_o pulses, then refresh is the next command before any pending wr/rd.
- ctrl_cmd_ready_i held 0 for 1600 cycles → refresh_overrun_o=1 and remains 1 after ready returns; ctrl_addr_o stays stable while valid is high.
- DRAM_RST_i asserted at beat 4 of a write → next cycle all outputs 0 and no wr_done_o. A subsequent rd_req_i is granted normally.

Source files
------------

// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter
//
// Shares the single SDRAM controller command port between the N64 input line
// writer (write requester) and the scaler line prefetch (read requester). It
// also schedules periodic auto-refresh. Each grant is a fixed BURST_LEN-beat
// burst. One command per grant goes to the controller over valid/ready, and
// data beats are counted until the burst completes. Runs in the DRAM clock
// domain.
//
// Ports:
//   DRAM_CLK_i         DRAM clock, all logic on the rising edge
//   DRAM_RST_i         synchronous active-high reset
//   wr_req_i/wr_addr_i write burst request and start address
//   wr_gnt_o           write grant, high from grant until the last beat
//   wr_done_o          one-cycle pulse on the last write beat
//   rd_req_i/rd_addr_i read burst request and start address
//   rd_gnt_o           read grant, high from grant until the last beat
//   rd_done_o          one-cycle pulse on the last read beat
//   ctrl_cmd_valid_o   command valid to the SDRAM controller
//   ctrl_cmd_ready_i   controller accepts the command
//   ctrl_cmd_o         00 none, 01 write, 10 read, 11 refresh
//   ctrl_addr_o        latched burst start address
//   ctrl_beat_i        one data beat transferred
//   ctrl_rfsh_done_i   refresh cycle finished
//   busy_o             arbiter is not idle
//   refresh_overrun_o  sticky: an interval elapsed with a refresh still pending
//
// Optional build macro SDRAM_ARB_STATS_EN adds stats_clr_i, wr_grants_o,
// rd_grants_o and max_wait_o (saturating grant counters and the longest
// request-to-grant wait).

module sdram_req_arbiter #(
    parameter int ADDR_W           = 22,
    parameter int BURST_LEN        = 8,
    parameter int REFRESH_INTERVAL = 780,
    parameter int MAX_RD_STREAK    = 4
) (
    input  logic              DRAM_CLK_i,
    input  logic              DRAM_RST_i,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    output logic              wr_gnt_o,
    output logic              wr_done_o,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_gnt_o,
    output logic              rd_done_o,
    output logic              ctrl_cmd_valid_o,
    input  logic              ctrl_cmd_ready_i,
    output logic [1:0]        ctrl_cmd_o,
    output logic [ADDR_W-1:0] ctrl_addr_o,
    input  logic              ctrl_beat_i,
    input  logic              ctrl_rfsh_done_i,
    output logic              busy_o,
    output logic              refresh_overrun_o
`ifdef SDRAM_ARB_STATS_EN
    ,
    input  logic              stats_clr_i,
    output logic [15:0]       wr_grants_o,
    output logic [15:0]       rd_grants_o,
    output logic [15:0]       max_wait_o
`endif
);

    localparam int RC_W = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int SW   = $clog2(MAX_RD_STREAK + 1);
    localparam int BC_W = 8;

    localparam logic [RC_W-1:0] RFSH_RELOAD = RC_W'(REFRESH_INTERVAL - 1);
    localparam logic [SW-1:0]   STREAK_MAX  = SW'(MAX_RD_STREAK);
    localparam logic [BC_W-1:0] LAST_BEAT   = BC_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_XFER,
        ST_RFSH
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE = 2'b00,
        CMD_WR   = 2'b01,
        CMD_RD   = 2'b10,
        CMD_RFSH = 2'b11
    } cmd_t;

    state_t            state_q, state_d;
    cmd_t              cmd_q, win_cmd;
    logic [ADDR_W-1:0] addr_q;
    logic [BC_W-1:0]   beat_cnt;
    logic [SW-1:0]     rd_streak;
    logic [RC_W-1:0]   rfsh_cnt;
    logic              rfsh_pend;
    logic              overrun_q;
    logic              burst_done;

    // State register.
    always_ff @(posedge DRAM_CLK_i) begin
        if (DRAM_RST_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration, next state and outputs. done/gnt react to the final beat in
    // the same cycle, so the requester sees the burst end with the last beat.
    always_comb begin
        state_d          = state_q;
        win_cmd          = CMD_NONE;
        burst_done       = 1'b0;
        ctrl_cmd_valid_o = 1'b0;
        ctrl_cmd_o       = CMD_NONE;
        wr_gnt_o         = 1'b0;
        rd_gnt_o         = 1'b0;
        wr_done_o        = 1'b0;
        rd_done_o        = 1'b0;
        busy_o           = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                // A write that has waited out a full read streak beats a read.
                if (rfsh_pend) begin
                    win_cmd = CMD_RFSH;
                end else if (wr_req_i && (rd_streak == STREAK_MAX)) begin
                    win_cmd = CMD_WR;
                end else if (rd_req_i) begin
                    win_cmd = CMD_RD;
                end else if (wr_req_i) begin
                    win_cmd = CMD_WR;
                end
                if (win_cmd != CMD_NONE) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (ctrl_cmd_ready_i) begin
                    state_d = (cmd_q == CMD_RFSH) ? ST_RFSH : ST_XFER;
                end
            end
            ST_XFER: begin
                if (ctrl_beat_i && (beat_cnt == LAST_BEAT)) begin
                    burst_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_RFSH: begin
                if (ctrl_rfsh_done_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_CMD) begin
            ctrl_cmd_valid_o = 1'b1;
            ctrl_cmd_o       = cmd_q;
        end
        if ((state_q == ST_CMD) || (state_q == ST_XFER)) begin
            wr_gnt_o = (cmd_q == CMD_WR) && !burst_done;
            rd_gnt_o = (cmd_q == CMD_RD) && !burst_done;
        end
        wr_done_o = burst_done && (cmd_q == CMD_WR);
        rd_done_o = burst_done && (cmd_q == CMD_RD);
    end

    // Datapath: refresh timer, latched command/address, beat counter and the
    // read streak used for write fairness. A timer expiry in the same cycle a
    // refresh is accepted re-arms the pending flag for the new interval.
    always_ff @(posedge DRAM_CLK_i) begin
        if (DRAM_RST_i) begin
            cmd_q     <= CMD_NONE;
            addr_q    <= '0;
            beat_cnt  <= '0;
            rd_streak <= '0;
            rfsh_pend <= 1'b0;
            rfsh_cnt  <= RFSH_RELOAD;
            overrun_q <= 1'b0;
        end else begin
            if (rfsh_cnt == '0) begin
                rfsh_cnt <= RFSH_RELOAD;
                if (rfsh_pend) begin
                    overrun_q <= 1'b1;
                end
            end else begin
                rfsh_cnt <= rfsh_cnt - RC_W'(1);
            end

            if (rfsh_cnt == '0) begin
                rfsh_pend <= 1'b1;
            end else if ((state_q == ST_CMD) && ctrl_cmd_ready_i && (cmd_q == CMD_RFSH)) begin
                rfsh_pend <= 1'b0;
            end

            if (state_q == ST_IDLE) begin
                if (win_cmd == CMD_RD) begin
                    if (rd_streak != STREAK_MAX) begin
                        rd_streak <= rd_streak + SW'(1);
                    end
                end else if ((win_cmd == CMD_WR) || !rd_req_i) begin
                    rd_streak <= '0;
                end

                if (win_cmd != CMD_NONE) begin
                    cmd_q    <= win_cmd;
                    beat_cnt <= '0;
                end
                if (win_cmd == CMD_WR) begin
                    addr_q <= wr_addr_i;
                end else if (win_cmd == CMD_RD) begin
                    addr_q <= rd_addr_i;
                end
            end

            if ((state_q == ST_XFER) && ctrl_beat_i) begin
                beat_cnt <= beat_cnt + BC_W'(1);
            end
        end
    end

    assign ctrl_addr_o       = addr_q;
    assign refresh_overrun_o = overrun_q;

`ifdef SDRAM_ARB_STATS_EN
    logic [15:0] wr_grants_q, rd_grants_q, max_wait_q;
    logic [15:0] wr_wait_q, rd_wait_q;
    logic [15:0] wr_wait_inc, rd_wait_inc;
    logic        wr_win, rd_win;

    assign wr_win = (state_q == ST_IDLE) && (win_cmd == CMD_WR);
    assign rd_win = (state_q == ST_IDLE) && (win_cmd == CMD_RD);

    // The wait reported for a grant includes the cycle the grant was decided.
    assign wr_wait_inc = (wr_wait_q == 16'hFFFF) ? 16'hFFFF : wr_wait_q + 16'd1;
    assign rd_wait_inc = (rd_wait_q == 16'hFFFF) ? 16'hFFFF : rd_wait_q + 16'd1;

    // Saturating grant counters and the longest request-to-grant wait.
    always_ff @(posedge DRAM_CLK_i) begin
        if (DRAM_RST_i || stats_clr_i) begin
            wr_grants_q <= '0;
            rd_grants_q <= '0;
            max_wait_q  <= '0;
            wr_wait_q   <= '0;
            rd_wait_q   <= '0;
        end else begin
            if (wr_win && (wr_grants_q != 16'hFFFF)) begin
                wr_grants_q <= wr_grants_q + 16'd1;
            end
            if (rd_win && (rd_grants_q != 16'hFFFF)) begin
                rd_grants_q <= rd_grants_q + 16'd1;
            end

            if (!wr_req_i || wr_win) begin
                wr_wait_q <= '0;
            end else begin
                wr_wait_q <= wr_wait_inc;
            end
            if (!rd_req_i || rd_win) begin
                rd_wait_q <= '0;
            end else begin
                rd_wait_q <= rd_wait_inc;
            end

            if (wr_win && (wr_wait_inc > max_wait_q)) begin
                max_wait_q <= wr_wait_inc;
            end else if (rd_win && (rd_wait_inc > max_wait_q)) begin
                max_wait_q <= rd_wait_inc;
            end
        end
    end

    assign wr_grants_o = wr_grants_q;
    assign rd_grants_o = rd_grants_q;
    assign max_wait_o  = max_wait_q;
`endif

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Testbench for sdram_req_arbiter: directed scenarios followed by a randomized
// run, all compared every cycle against a behavioural model of the arbiter.
module tb_sdram_req_arbiter;

    localparam int ADDR_W     = 22;
    localparam int BURST_LEN  = 8;
    localparam int RFSH_INT   = 780;
    localparam int MAX_STREAK = 4;

    localparam int OWN_WR     = 1;
    localparam int OWN_RD     = 2;
    localparam int OWN_RF     = 3;
    localparam int EV_RD_DONE = 4;
    localparam int EV_WR_DONE = 5;

    localparam int PH_IDLE = 0;
    localparam int PH_CMD  = 1;
    localparam int PH_XFER = 2;
    localparam int PH_RFSH = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_req, rd_req;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              wr_gnt, wr_done, rd_gnt, rd_done;
    logic              cmd_valid, cmd_ready;
    logic [1:0]        cmd_code;
    logic [ADDR_W-1:0] cmd_addr;
    logic              beat, rfsh_done;
    logic              busy, overrun;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int                m_phase, m_owner, m_beats, m_streak, m_edges, m_served;
    bit                m_ovr, m_addr_known;
    logic [ADDR_W-1:0] m_addr;
    int                evlog[$];

    sdram_req_arbiter dut (
        .DRAM_CLK_i        (clk),
        .DRAM_RST_i        (rst),
        .wr_req_i          (wr_req),
        .wr_addr_i         (wr_addr),
        .wr_gnt_o          (wr_gnt),
        .wr_done_o         (wr_done),
        .rd_req_i          (rd_req),
        .rd_addr_i         (rd_addr),
        .rd_gnt_o          (rd_gnt),
        .rd_done_o         (rd_done),
        .ctrl_cmd_valid_o  (cmd_valid),
        .ctrl_cmd_ready_i  (cmd_ready),
        .ctrl_cmd_o        (cmd_code),
        .ctrl_addr_o       (cmd_addr),
        .ctrl_beat_i       (beat),
        .ctrl_rfsh_done_i  (rfsh_done),
        .busy_o            (busy),
        .refresh_overrun_o (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_phase      = PH_IDLE;
        m_owner      = 0;
        m_beats      = 0;
        m_streak     = 0;
        m_edges      = 0;
        m_served     = 0;
        m_ovr        = 1'b0;
        m_addr       = '0;
        m_addr_known = 1'b1;
    endtask

    // One clock: compare outputs with the model for the inputs currently
    // driven, then advance the model across the rising edge.
    task automatic applyStimulus();
        bit done_now, in_burst, pend;
        int win;
        #1;
        done_now = (m_phase == PH_XFER) && beat && (m_beats == BURST_LEN - 1);
        in_burst = (m_phase == PH_CMD) || (m_phase == PH_XFER);
        checkOutput("cmd_valid", 32'(cmd_valid), 32'(m_phase == PH_CMD));
        checkOutput("cmd_code", 32'(cmd_code), (m_phase == PH_CMD) ? m_owner : 0);
        checkOutput("wr_gnt", 32'(wr_gnt), 32'(in_burst && m_owner == OWN_WR && !done_now));
        checkOutput("rd_gnt", 32'(rd_gnt), 32'(in_burst && m_owner == OWN_RD && !done_now));
        checkOutput("wr_done", 32'(wr_done), 32'(done_now && m_owner == OWN_WR));
        checkOutput("rd_done", 32'(rd_done), 32'(done_now && m_owner == OWN_RD));
        checkOutput("busy", 32'(busy), 32'(m_phase != PH_IDLE));
        checkOutput("overrun", 32'(overrun), 32'(m_ovr));
        if (m_addr_known) checkOutput("cmd_addr", 32'(cmd_addr), 32'(m_addr));
        if (cmd_valid && cmd_ready) evlog.push_back(int'(cmd_code));
        if (rd_done) evlog.push_back(EV_RD_DONE);
        if (wr_done) evlog.push_back(EV_WR_DONE);

        @(posedge clk);
        if (rst) begin
            modelReset();
        end else begin
            // Intervals elapsed so far versus refreshes that covered them.
            pend = ((m_edges / RFSH_INT) > m_served);
            m_edges++;
            if ((m_edges % RFSH_INT == 0) && pend) m_ovr = 1'b1;
            case (m_phase)
                PH_IDLE: begin
                    win = 0;
                    if (pend) win = OWN_RF;
                    else if (wr_req && m_streak == MAX_STREAK) win = OWN_WR;
                    else if (rd_req) win = OWN_RD;
                    else if (wr_req) win = OWN_WR;
                    if (win == OWN_RD) m_streak = (m_streak < MAX_STREAK) ? m_streak + 1 : MAX_STREAK;
                    else if (win == OWN_WR || !rd_req) m_streak = 0;
                    if (win != 0) begin
                        m_phase = PH_CMD;
                        m_owner = win;
                        m_beats = 0;
                        if (win == OWN_WR) begin
                            m_addr = wr_addr;
                            m_addr_known = 1'b1;
                        end else if (win == OWN_RD) begin
                            m_addr = rd_addr;
                            m_addr_known = 1'b1;
                        end else begin
                            m_addr_known = 1'b0;
                        end
                    end
                end
                PH_CMD: begin
                    if (cmd_ready) begin
                        if (m_owner == OWN_RF) begin
                            m_served = (m_edges - 1) / RFSH_INT;
                            m_phase  = PH_RFSH;
                        end else begin
                            m_phase = PH_XFER;
                        end
                    end
                end
                PH_XFER: begin
                    if (beat) begin
                        m_beats++;
                        if (m_beats == BURST_LEN) m_phase = PH_IDLE;
                    end
                end
                default: begin
                    if (rfsh_done) m_phase = PH_IDLE;
                end
            endcase
        end
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
    endtask

    initial begin
        int cmds[$];
        int pattern[10];
        logic [ADDR_W-1:0] held_addr;

        pattern = '{OWN_RD, OWN_RD, OWN_RD, OWN_RD, OWN_WR, OWN_RD, OWN_RD, OWN_RD, OWN_RD, OWN_WR};
        rst = 1'b1; wr_req = 0; rd_req = 0; wr_addr = '0; rd_addr = '0;
        cmd_ready = 0; beat = 0; rfsh_done = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        modelReset();
        rst = 1'b0;

        // Reset state
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_valid", 32'(cmd_valid), 0);
        checkOutput("reset_addr", 32'(cmd_addr), 0);

        // First refresh after an idle interval
        repeat (RFSH_INT) applyStimulus();
        checkOutput("rfsh_not_early", 32'(cmd_valid), 0);
        applyStimulus();
        checkOutput("rfsh_valid_781", 32'(cmd_valid), 1);
        checkOutput("rfsh_cmd_781", 32'(cmd_code), 3);
        cmd_ready = 1; applyStimulus();
        cmd_ready = 0; applyStimulus(); applyStimulus();
        rfsh_done = 1; applyStimulus();
        rfsh_done = 0;
        checkOutput("rfsh_back_idle", 32'(busy), 0);
        checkOutput("rfsh_no_overrun", 32'(overrun), 0);

        // Single write burst
        wr_req = 1; wr_addr = 22'h000123; cmd_ready = 1;
        applyStimulus();
        checkOutput("wr_gnt_latency", 32'(wr_gnt), 1);
        checkOutput("wr_cmd_code", 32'(cmd_code), 1);
        checkOutput("wr_cmd_addr", 32'(cmd_addr), 32'h123);
        wr_req = 0;
        applyStimulus();
        beat = 1;
        repeat (BURST_LEN - 1) applyStimulus();
        #1;
        checkOutput("wr_done_beat8", 32'(wr_done), 1);
        checkOutput("wr_gnt_drop_beat8", 32'(wr_gnt), 0);
        applyStimulus();
        beat = 0; cmd_ready = 0;
        checkOutput("wr_idle_after", 32'(busy), 0);

        // Read/write fairness with both requests held continuously
        doReset();
        wr_req = 1; rd_req = 1; cmd_ready = 1; beat = 1;
        wr_addr = 22'(32'h2AAAA); rd_addr = 22'(32'h15555);
        evlog.delete();
        for (int i = 0; i < 300 && cmds.size() < 10; i++) begin
            applyStimulus();
            cmds.delete();
            foreach (evlog[k]) if (evlog[k] <= OWN_RF) cmds.push_back(evlog[k]);
        end
        checkOutput("fair_cmd_count", 32'(cmds.size() >= 10), 1);
        for (int i = 0; i < 10; i++)
            checkOutput($sformatf("fair_order_%0d", i), (i < cmds.size()) ? cmds[i] : -1, pattern[i]);
        wr_req = 0; rd_req = 0; beat = 0; cmd_ready = 0;

        // Refresh falls due in the middle of a read burst
        doReset();
        repeat (RFSH_INT - 5) applyStimulus();
        rd_req = 1; rd_addr = 22'($urandom); wr_req = 1; wr_addr = 22'($urandom); cmd_ready = 1;
        evlog.delete();
        for (int i = 0; i < 100 && evlog.size() < 3; i++) begin
            beat = i[0];
            applyStimulus();
        end
        checkOutput("midrf_first_rd", (evlog.size() > 0) ? evlog[0] : -1, OWN_RD);
        checkOutput("midrf_rd_done", (evlog.size() > 1) ? evlog[1] : -1, EV_RD_DONE);
        checkOutput("midrf_then_rfsh", (evlog.size() > 2) ? evlog[2] : -1, OWN_RF);
        wr_req = 0; rd_req = 0; beat = 0; cmd_ready = 0;
        rfsh_done = 1; applyStimulus(); rfsh_done = 0;

        // Controller stalls long enough for a refresh interval to be missed
        doReset();
        held_addr = 22'($urandom);
        wr_req = 1; wr_addr = held_addr; cmd_ready = 0;
        applyStimulus();
        wr_req = 0; wr_addr = ~held_addr;
        repeat (1600) applyStimulus();
        checkOutput("stall_overrun", 32'(overrun), 1);
        checkOutput("stall_valid", 32'(cmd_valid), 1);
        checkOutput("stall_addr", 32'(cmd_addr), 32'(held_addr));
        cmd_ready = 1; applyStimulus();
        beat = 1; repeat (BURST_LEN) applyStimulus();
        beat = 0; rfsh_done = 1;
        repeat (10) applyStimulus();
        rfsh_done = 0; cmd_ready = 0;
        checkOutput("stall_overrun_sticky", 32'(overrun), 1);

        // Reset in the middle of a write burst
        doReset();
        wr_req = 1; wr_addr = 22'h0ABCDE; cmd_ready = 1;
        applyStimulus();
        wr_req = 0;
        applyStimulus();
        beat = 1;
        repeat (3) applyStimulus();
        rst = 1;
        applyStimulus();
        rst = 0; beat = 0; cmd_ready = 0;
        checkOutput("mrst_busy", 32'(busy), 0);
        checkOutput("mrst_wr_gnt", 32'(wr_gnt), 0);
        checkOutput("mrst_wr_done", 32'(wr_done), 0);
        checkOutput("mrst_addr", 32'(cmd_addr), 0);
        rd_req = 1; rd_addr = 22'h03C3C3;
        applyStimulus();
        checkOutput("mrst_rd_gnt", 32'(rd_gnt), 1);
        checkOutput("mrst_rd_cmd", 32'(cmd_code), 2);
        rd_req = 0; cmd_ready = 1; beat = 1;
        repeat (BURST_LEN + 2) applyStimulus();
        beat = 0; cmd_ready = 0;

        // Randomized traffic, including stray beats and refresh-done pulses
        doReset();
        for (int i = 0; i < 4000; i++) begin
            if (!wr_req) begin
                wr_req = ($urandom_range(0, 3) == 0);
                wr_addr = 22'($urandom);
            end else if (wr_gnt || $urandom_range(0, 31) == 0) begin
                wr_req = 0;
            end
            if (!rd_req) begin
                rd_req = ($urandom_range(0, 2) == 0);
                rd_addr = 22'($urandom);
            end else if (rd_gnt || $urandom_range(0, 31) == 0) begin
                rd_req = 0;
            end
            cmd_ready = ($urandom_range(0, 2) == 0);
            beat      = 1'($urandom_range(0, 1));
            rfsh_done = ($urandom_range(0, 3) == 0);
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
